// File: rtl/sbox_pkg.sv
`default_nettype none
// ============================================================================
// sbox_pkg : shared constants, GF(2^8) multiply and AES affine helpers
// Build option: SBOX_STREAM_INV_EN (consumed by sbox_stream)
// Revision : 1.0
// ============================================================================
package sbox_pkg;

    localparam logic [7:0] SBOX_AFF_C     = 8'h63;
    localparam logic [7:0] SBOX_INV_AFF_C = 8'h05;
    localparam logic [8:0] SBOX_GF_POLY   = 9'h11B;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? SBOX_GF_POLY[7:0] : 8'h00);
        end
        return acc;
    endfunction

    // Forward affine A(x)^63, written as rotate-right XORs.
    function automatic logic [7:0] aff_fwd(input logic [7:0] x);
        return x ^ {x[3:0], x[7:4]} ^ {x[4:0], x[7:5]} ^ {x[5:0], x[7:6]}
                 ^ {x[6:0], x[7]} ^ SBOX_AFF_C;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] y);
        return {y[1:0], y[7:2]} ^ {y[4:0], y[7:5]} ^ {y[6:0], y[7]} ^ SBOX_INV_AFF_C;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gf256_inv_byte.sv
`default_nettype none
// ============================================================================
// gf256_inv_byte : combinational GF(2^8) multiplicative inverse, inv(0)=0
// Revision : 1.0
// ============================================================================
module gf256_inv_byte
    import sbox_pkg::*;
(
    input  logic [7:0] i_x,
    output logic [7:0] o_y
);

    // x^254 = x^-1 for x != 0, and 0 for x = 0
    logic [7:0] w_p2, w_p4, w_p8, w_p16, w_p32, w_p64, w_p128;

    assign w_p2   = gf_mul(i_x,  i_x);
    assign w_p4   = gf_mul(w_p2, w_p2);
    assign w_p8   = gf_mul(w_p4, w_p4);
    assign w_p16  = gf_mul(w_p8, w_p8);
    assign w_p32  = gf_mul(w_p16, w_p16);
    assign w_p64  = gf_mul(w_p32, w_p32);
    assign w_p128 = gf_mul(w_p64, w_p64);

    assign o_y = gf_mul(gf_mul(gf_mul(w_p2, w_p4), gf_mul(w_p8, w_p16)),
                        gf_mul(gf_mul(w_p32, w_p64), w_p128));

endmodule
`default_nettype wire

// File: rtl/sbox_stream.sv
`default_nettype none
// ============================================================================
// sbox_stream : 2-stage elastic AES S-box / inverse S-box over LANES bytes
// Build option: SBOX_STREAM_INV_EN enables per-word inverse mode
// Revision : 1.0
// ============================================================================
module sbox_stream
    import sbox_pkg::*;
#(
    parameter int LANES = 4,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic                 in_inv,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic                 out_inv,
    output logic [TAG_W-1:0]     out_tag
);

    logic                 r_v1, r_v2;
    logic [8*LANES-1:0]   r_d1, r_d2;
    logic                 r_inv1, r_inv2;
    logic [TAG_W-1:0]     r_tag1, r_tag2;
    logic                 w_adv1, w_adv2;
    logic                 w_inv_in;
    logic [8*LANES-1:0]   w_pre, w_post;

`ifdef SBOX_STREAM_INV_EN
    assign w_inv_in = in_inv;
`else
    logic w_unused_inv;
    assign w_unused_inv = in_inv;
    assign w_inv_in     = 1'b0;
`endif

    assign w_adv2   = !r_v2 | out_ready;
    assign w_adv1   = !r_v1 | w_adv2;
    assign in_ready = w_adv1;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] w_in_b;
        logic [7:0] w_gi;

        assign w_in_b = in_data[8*l +: 8];

        gf256_inv_byte u_inv (
            .i_x (r_d1[8*l +: 8]),
            .o_y (w_gi)
        );

`ifdef SBOX_STREAM_INV_EN
        assign w_pre[8*l +: 8]  = w_inv_in ? aff_inv(w_in_b) : w_in_b;
        assign w_post[8*l +: 8] = r_inv1 ? w_gi : aff_fwd(w_gi);
`else
        assign w_pre[8*l +: 8]  = w_in_b;
        assign w_post[8*l +: 8] = aff_fwd(w_gi);
`endif
    end

    // Payload registers only move when a real word enters, so bubbles never disturb them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_d1   <= '0;
            r_inv1 <= 1'b0;
            r_tag1 <= '0;
        end else if (w_adv1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_d1   <= w_pre;
                r_inv1 <= w_inv_in;
                r_tag1 <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2   <= 1'b0;
            r_d2   <= '0;
            r_inv2 <= 1'b0;
            r_tag2 <= '0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_d2   <= w_post;
                r_inv2 <= r_inv1;
                r_tag2 <= r_tag1;
            end
        end
    end

    assign out_valid = r_v2;
    assign out_data  = r_d2;
    assign out_inv   = r_inv2;
    assign out_tag   = r_tag2;

endmodule
`default_nettype wire
